// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event chain: event kind codes and the
// event-generator FSM state encoding. Imported by the generator and by the
// consumer FSMs that decode evt_kind.
package button_event_gen_pkg;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

endpackage

// File: rtl/button_event_gen_hold_timer.sv
// Hold timer for auto-repeat.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   sel      : limit select, 0 = HOLD_CYC, 1 = REPEAT_CYC
//   tc       : terminal count, cnt == selected limit - 1
module button_event_gen_hold_timer #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel,
  output logic tc
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == (sel ? REP_LIM : HOLD_LIM));

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: turns a debounced level into PRESS / RELEASE
// (and, with AUTO_REPEAT_EN defined, REPEAT) events offered one at a time
// through a single-entry valid/ready slot.
//   clk       : system clock
//   rst       : async reset, active-low
//   btn_lvl   : debounced level, 1 = pressed
//   evt_valid : event pending
//   evt_kind  : 01 PRESS, 10 RELEASE, 11 REPEAT
//   evt_ready : consumer accept
//   evt_ovf   : one-cycle pulse, an event was dropped (slot full)
// Build option: AUTO_REPEAT_EN enables the hold timer and REPEAT events.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_lvl,
  output logic       evt_valid,
  output logic [1:0] evt_kind,
  input  logic       evt_ready,
  output logic       evt_ovf
);

  logic       btn_q;
  logic       rise, fall;
  state_t     state, state_nxt;
  logic       raise;
  logic [1:0] raise_kind;

  // btn_q starts at 0, so a button held through reset release shows up as
  // a rise in the first cycle and produces a PRESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn_lvl;
  end

  assign rise = btn_lvl & ~btn_q;
  assign fall = ~btn_lvl & btn_q;

`ifdef AUTO_REPEAT_EN
  logic tmr_clr, tmr_en, tmr_sel, tmr_tc;

  button_event_gen_hold_timer #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .CNT_W     (CNT_W)
  ) u_tmr (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .en (tmr_en),
    .sel(tmr_sel),
    .tc (tmr_tc)
  );
`else
  // Timer configuration is meaningless without auto-repeat.
  logic unused_cfg;
  assign unused_cfg = ^{32'(HOLD_CYC), 32'(REPEAT_CYC), 32'(CNT_W)};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Fall is tested before timer expiry so a release in the expiry cycle
  // yields only RELEASE.
  always_comb begin
    state_nxt  = state;
    raise      = 1'b0;
    raise_kind = EVT_NONE;
`ifdef AUTO_REPEAT_EN
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
    tmr_sel    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt  = ST_HELD;
          raise      = 1'b1;
          raise_kind = EVT_PRESS;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_nxt  = ST_IDLE;
          raise      = 1'b1;
          raise_kind = EVT_RELEASE;
        end
`ifdef AUTO_REPEAT_EN
        else if (tmr_tc) begin
          state_nxt  = ST_REPEAT;
          raise      = 1'b1;
          raise_kind = EVT_REPEAT;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      ST_REPEAT: begin
        tmr_sel = 1'b1;
        if (fall) begin
          state_nxt  = ST_IDLE;
          raise      = 1'b1;
          raise_kind = EVT_RELEASE;
        end else if (tmr_tc) begin
          raise      = 1'b1;
          raise_kind = EVT_REPEAT;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-entry output slot. A raise loads when the slot is empty or being
  // drained this cycle; otherwise it is dropped and flagged, and the FSM
  // carries on regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_kind  <= EVT_NONE;
      evt_ovf   <= 1'b0;
    end else begin
      evt_ovf <= 1'b0;
      if (raise) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_kind  <= raise_kind;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
        evt_kind  <= EVT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with HOLD_CYC=8, REPEAT_CYC=4.
// Inputs change 1 ns after the rising edge; outputs are checked there too,
// so "cycle N" below means the interval following rising edge N.
// REPEAT expectations follow the AUTO_REPEAT_EN build option.
module tb_button_event_gen;
  import button_event_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_lvl;
  logic       evt_valid;
  logic [1:0] evt_kind;
  logic       evt_ready;
  logic       evt_ovf;

  int checks = 0;
  int errors = 0;

  button_event_gen #(
    .HOLD_CYC  (8),
    .REPEAT_CYC(4),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_lvl  (btn_lvl),
    .evt_valid(evt_valid),
    .evt_kind (evt_kind),
    .evt_ready(evt_ready),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected slot content per cycle for the long hold (press at 0, fall at 20).
  function automatic logic [1:0] t2_exp(input int c);
    if (c == 1)  return EVT_PRESS;
    if (c == 21) return EVT_RELEASE;
`ifdef AUTO_REPEAT_EN
    if (c == 9 || c == 13 || c == 17) return EVT_REPEAT;
`endif
    return EVT_NONE;
  endfunction

  initial begin
    logic [1:0] e;

    // 1: reset with button released
    rst = 1'b0; btn_lvl = 1'b0; evt_ready = 1'b1;
    #3;
    chk("rst_valid", {1'b0, evt_valid}, 2'd0);
    chk("rst_kind",  evt_kind,          2'd0);
    chk("rst_ovf",   {1'b0, evt_ovf},   2'd0);
    tick(); tick();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", {1'b0, evt_valid}, 2'd0);
      chk("idle_ovf",   {1'b0, evt_ovf},   2'd0);
    end

    // 2: long hold, repeats, release coinciding with expiry
    for (int c = 0; c <= 23; c++) begin
      e = t2_exp(c);
      chk($sformatf("hold_valid_c%0d", c), {1'b0, evt_valid}, {1'b0, e != EVT_NONE});
      if (e != EVT_NONE) chk($sformatf("hold_kind_c%0d", c), evt_kind, e);
      btn_lvl = (c <= 19);
      tick();
    end

    // 3: short tap, 1 for cycles 0-2
    for (int c = 0; c <= 6; c++) begin
      e = (c == 1) ? EVT_PRESS : (c == 4) ? EVT_RELEASE : EVT_NONE;
      chk($sformatf("tap_valid_c%0d", c), {1'b0, evt_valid}, {1'b0, e != EVT_NONE});
      if (e != EVT_NONE) chk($sformatf("tap_kind_c%0d", c), evt_kind, e);
      btn_lvl = (c <= 2);
      tick();
    end

    // 4: consumer stalled, RELEASE dropped while PRESS pending
    evt_ready = 1'b0;
    btn_lvl = 1'b1;
    tick();
    chk("ovf_press_valid", {1'b0, evt_valid}, 2'd1);
    chk("ovf_press_kind",  evt_kind,          EVT_PRESS);
    chk("ovf_none_yet",    {1'b0, evt_ovf},   2'd0);
    btn_lvl = 1'b0;
    tick();
    chk("ovf_pulse",       {1'b0, evt_ovf},   2'd1);
    chk("ovf_kind_held",   evt_kind,          EVT_PRESS);
    chk("ovf_valid_held",  {1'b0, evt_valid}, 2'd1);
    tick();
    chk("ovf_one_cycle",   {1'b0, evt_ovf},   2'd0);
    chk("ovf_kind_still",  evt_kind,          EVT_PRESS);
    evt_ready = 1'b1;
    tick();
    chk("ovf_drained",     {1'b0, evt_valid}, 2'd0);
    evt_ready = 1'b0;
    tick(); tick();
    chk("ovf_stays_empty", {1'b0, evt_valid}, 2'd0);

    // 5: reset during a held press, released with button still held
    btn_lvl = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("mid_pending",     {1'b0, evt_valid}, 2'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid",   {1'b0, evt_valid}, 2'd0);
    chk("mid_rst_kind",    evt_kind,          2'd0);
    evt_ready = 1'b1;
    tick(); tick();
    chk("mid_rst_hold",    {1'b0, evt_valid}, 2'd0);
    chk("mid_rst_ovf",     {1'b0, evt_ovf},   2'd0);
    rst = 1'b1;
    chk("post_rst_empty",  {1'b0, evt_valid}, 2'd0);
    tick();
    chk("post_rst_valid",  {1'b0, evt_valid}, 2'd1);
    chk("post_rst_kind",   evt_kind,          EVT_PRESS);
    btn_lvl = 1'b0;
    tick();
    chk("post_rst_rel",    evt_kind,          EVT_RELEASE);
    tick(); tick();
    chk("post_rst_idle",   {1'b0, evt_valid}, 2'd0);

`ifndef AUTO_REPEAT_EN
    // 6: 30-cycle hold without auto-repeat: PRESS and RELEASE only
    for (int c = 0; c <= 33; c++) begin
      e = (c == 1) ? EVT_PRESS : (c == 31) ? EVT_RELEASE : EVT_NONE;
      chk($sformatf("norep_valid_c%0d", c), {1'b0, evt_valid}, {1'b0, e != EVT_NONE});
      if (e != EVT_NONE) chk($sformatf("norep_kind_c%0d", c), evt_kind, e);
      chk($sformatf("norep_not11_c%0d", c), {1'b0, evt_kind == EVT_REPEAT}, 2'd0);
      btn_lvl = (c <= 29);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
